// File: rtl/firebird7_in_gate1_tessent_tdr_data_ctrl_w3_if.sv
// firebird7_in_gate1_tessent_tdr_data_ctrl_w3_if: IJTAG segment controls and scan (sel/ce/se/ue/si/so) plus mux observe/select/data signals
interface firebird7_in_gate1_tessent_tdr_data_ctrl_w3_if #(
  parameter int DATA_WIDTH = 3
);
  logic ijtag_sel;
  logic ijtag_ce;
  logic ijtag_se;
  logic ijtag_ue;
  logic ijtag_si;
  logic ijtag_so;
  logic [DATA_WIDTH-1:0] observe_data;
  logic ijtag_select;
  logic [DATA_WIDTH-1:0] ijtag_data_out;
  modport master (
    output ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, observe_data,
    input ijtag_so, ijtag_select, ijtag_data_out
  );
  modport slave (
    input ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, observe_data,
    output ijtag_so, ijtag_select, ijtag_data_out
  );
endinterface

// File: rtl/firebird7_in_gate1_tessent_tdr_data_ctrl_w3.sv
// firebird7_in_gate1_tessent_tdr_data_ctrl_w3: IJTAG TDR (ijtag_tck, async ijtag_reset, bus.slave) driving gate1 mux select/data and capturing observe data
module firebird7_in_gate1_tessent_tdr_data_ctrl_w3 #(
  parameter int DATA_WIDTH = 3,
  parameter logic RESET_SELECT = 1'b0,
  parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
  input logic ijtag_tck,
  input logic ijtag_reset,
  firebird7_in_gate1_tessent_tdr_data_ctrl_w3_if.slave bus
);
  localparam int N = DATA_WIDTH + 1;
  logic [N-1:0] r_sr;
  logic [N-1:0] r_ur;
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      r_sr <= {RESET_DATA, RESET_SELECT};
      r_ur <= {RESET_DATA, RESET_SELECT};
    end else if (bus.ijtag_sel) begin
      r_sr <= bus.ijtag_ce ? {bus.observe_data, r_ur[0]} :
              bus.ijtag_se ? {bus.ijtag_si, r_sr[N-1:1]} : r_sr;
      if (bus.ijtag_ue) r_ur <= r_sr;
    end
  end
  assign bus.ijtag_so = r_sr[0];
  assign bus.ijtag_select = r_ur[0];
  assign bus.ijtag_data_out = r_ur[N-1:1];
endmodule
